ysyx_22040175_mem_arb: RTL and testbench



---
 rtl/ysyx_22040175_mem_arb_pkg.sv | 24 ++
 rtl/ysyx_22040175_arb_pick.sv | 42 ++++
 rtl/ysyx_22040175_mem_arb.sv | 160 ++++++++++++++++
 tb/tb_ysyx_22040175_mem_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040175_mem_arb_pkg.sv
// Shared types and default widths for the ysyx_22040175 IFU/LSU memory arbiter.
package ysyx_22040175_mem_arb_pkg;

    localparam int ARB_ADDR_W       = 32;
    localparam int ARB_DATA_W       = 64;
    localparam int ARB_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

    // Grant one-hot: bit 0 = IFU, bit 1 = LSU.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IFU  = 2'b01;
    localparam logic [1:0] GNT_LSU  = 2'b10;

endpackage

// File: rtl/ysyx_22040175_arb_pick.sv
// Combinational grant selection: LSU has priority unless the IFU has already
// waited through STARVE_LIMIT consecutive LSU grants.
module ysyx_22040175_arb_pick
    import ysyx_22040175_mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             ifu_valid,
    input  logic             lsu_valid,
    input  logic [CNT_W-1:0] streak,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] streak_next
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // winner selection and streak bookkeeping for a grant in this cycle
    always_comb begin
        grant       = GNT_NONE;
        streak_next = streak;
        if (lsu_valid && !(ifu_valid && (streak >= LIMIT))) begin
            grant = GNT_LSU;
            if (ifu_valid) begin
                if (streak >= LIMIT) begin
                    streak_next = LIMIT;
                end else begin
                    streak_next = streak + CNT_W'(1'b1);
                end
            end else begin
                streak_next = {CNT_W{1'b0}};
            end
        end else if (ifu_valid) begin
            grant       = GNT_IFU;
            streak_next = {CNT_W{1'b0}};
        end else begin
            grant       = GNT_NONE;
            streak_next = streak;
        end
    end

endmodule

// File: rtl/ysyx_22040175_mem_arb.sv
// Single-port memory arbiter between instruction fetch and load/store, one
// transaction in flight, responses routed back to whoever owns the port.
module ysyx_22040175_mem_arb
    import ysyx_22040175_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);

    arb_state_e       state_r;
    arb_state_e       state_next_s;
    arb_owner_e       owner_r;
    logic [CNT_W-1:0] streak_r;
    logic [CNT_W-1:0] streak_next_s;
    logic [1:0]       grant_s;
    logic             grant_fire_s;

    logic              mem_req_valid_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_wen_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [MASK_W-1:0] mem_wmask_r;

    assign mem_req_valid = mem_req_valid_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wen       = mem_wen_r;
    assign mem_wdata     = mem_wdata_r;
    assign mem_wmask     = mem_wmask_r;

    ysyx_22040175_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .ifu_valid   (ifu_req_valid),
        .lsu_valid   (lsu_req_valid),
        .streak      (streak_r),
        .grant       (grant_s),
        .streak_next (streak_next_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // next state and upstream ready; readys are held low while rst is asserted
    always_comb begin
        state_next_s  = state_r;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        grant_fire_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rst && (grant_s != GNT_NONE)) begin
                    grant_fire_s  = 1'b1;
                    ifu_req_ready = grant_s[0];
                    lsu_req_ready = grant_s[1];
                    state_next_s  = ST_REQ;
                end else begin
                    state_next_s  = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // capture the winning request and track owner/streak
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r         <= OWN_IFU;
            streak_r        <= {CNT_W{1'b0}};
            mem_req_valid_r <= 1'b0;
            mem_addr_r      <= {ADDR_W{1'b0}};
            mem_wen_r       <= 1'b0;
            mem_wdata_r     <= {DATA_W{1'b0}};
            mem_wmask_r     <= {MASK_W{1'b0}};
        end else if (grant_fire_s) begin
            owner_r         <= grant_s[1] ? OWN_LSU : OWN_IFU;
            streak_r        <= streak_next_s;
            mem_req_valid_r <= 1'b1;
            mem_addr_r      <= grant_s[1] ? lsu_addr : ifu_addr;
            mem_wen_r       <= grant_s[1] & lsu_wen;
            mem_wdata_r     <= grant_s[1] ? lsu_wdata : {DATA_W{1'b0}};
            mem_wmask_r     <= grant_s[1] ? lsu_wmask : {MASK_W{1'b0}};
        end else if ((state_r == ST_REQ) && mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
        end else begin
            mem_req_valid_r <= mem_req_valid_r;
        end
    end

    // response pass-through to the owner only; responses outside WAIT are dropped
    always_comb begin
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        ifu_rdata     = {DATA_W{1'b0}};
        lsu_rdata     = {DATA_W{1'b0}};
        if (!rst && (state_r == ST_WAIT)) begin
            if (owner_r == OWN_LSU) begin
                lsu_rsp_valid = mem_rsp_valid;
                lsu_rdata     = mem_rdata;
            end else begin
                ifu_rsp_valid = mem_rsp_valid;
                ifu_rdata     = mem_rdata;
            end
        end else begin
            ifu_rsp_valid = 1'b0;
            lsu_rsp_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_22040175_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter with a transaction-level
// reference model compared against every output on every cycle.
module tb_ysyx_22040175_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr;
    logic [63:0] ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [31:0] lsu_addr;
    logic [63:0] lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int n_chk  = 0;
    int n_fail = 0;

    ysyx_22040175_mem_arb dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: one in-flight transaction record plus a starvation count.
    bit          m_busy, m_acc, m_owner;
    logic [31:0] m_addr;
    logic        m_wen;
    logic [63:0] m_wdata;
    logic [7:0]  m_wmask;
    int          m_streak;

    // 0 = nobody, 1 = IFU, 2 = LSU
    function automatic int pick(input logic ifv, input logic lsv, input int s);
        if (lsv && !(ifv && s >= 4)) return 2;
        if (ifv) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_acc <= 1'b0; m_owner <= 1'b0; m_streak <= 0;
            m_addr <= '0; m_wen <= 1'b0; m_wdata <= '0; m_wmask <= '0;
        end else if (!m_busy) begin
            case (pick(ifu_req_valid, lsu_req_valid, m_streak))
                2: begin
                    m_busy <= 1'b1; m_acc <= 1'b0; m_owner <= 1'b1;
                    m_addr <= lsu_addr; m_wen <= lsu_wen; m_wdata <= lsu_wdata; m_wmask <= lsu_wmask;
                    m_streak <= ifu_req_valid ? ((m_streak + 1 > 4) ? 4 : m_streak + 1) : 0;
                end
                1: begin
                    m_busy <= 1'b1; m_acc <= 1'b0; m_owner <= 1'b0;
                    m_addr <= ifu_addr; m_wen <= 1'b0; m_wdata <= '0; m_wmask <= '0;
                    m_streak <= 0;
                end
                default: ;
            endcase
        end else if (!m_acc) begin
            if (mem_req_ready) m_acc <= 1'b1;
        end else if (mem_rsp_valid) begin
            m_busy <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        int   w;
        logic in_rsp;
        w      = (!rst && !m_busy) ? pick(ifu_req_valid, lsu_req_valid, m_streak) : 0;
        in_rsp = !rst && m_busy && m_acc;
        chk("m_ifu_req_ready", 64'(ifu_req_ready), 64'(w == 1));
        chk("m_lsu_req_ready", 64'(lsu_req_ready), 64'(w == 2));
        chk("m_mem_req_valid", 64'(mem_req_valid), 64'(m_busy && !m_acc));
        chk("m_mem_addr",      64'(mem_addr),      64'(m_addr));
        chk("m_mem_wen",       64'(mem_wen),       64'(m_wen));
        chk("m_mem_wdata",     mem_wdata,          m_wdata);
        chk("m_mem_wmask",     64'(mem_wmask),     64'(m_wmask));
        chk("m_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'(in_rsp && !m_owner && mem_rsp_valid));
        chk("m_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(in_rsp && m_owner && mem_rsp_valid));
        chk("m_ifu_rdata",     ifu_rdata,          (in_rsp && !m_owner) ? mem_rdata : 64'h0);
        chk("m_lsu_rdata",     lsu_rdata,          (in_rsp && m_owner) ? mem_rdata : 64'h0);
    endtask

    task automatic sample(); @(negedge clk); compare_all(); endtask
    task automatic adv();    @(posedge clk); #1;            endtask
    task automatic tick();   sample(); adv();               endtask

    // accept after acc_wait cycles, then respond on the following cycle
    task automatic serve(input int acc_wait, input logic [63:0] data);
        repeat (acc_wait) tick();
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = data; tick();
        mem_rsp_valid = 1'b0; mem_rdata = 64'h0;
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 64'h0; lsu_wmask = 8'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 64'h0;
        tick(); tick();
        rst = 1'b0;
        sample();
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'h0);
        chk("rst_mem_addr", 64'(mem_addr), 64'h0);
        chk("rst_ifu_req_ready", 64'(ifu_req_ready), 64'h0);
        adv();

        // IFU-only read, data two cycles after accept
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        sample();
        chk("ifu_ready_t", 64'(ifu_req_ready), 64'h1);
        chk("lsu_ready_t", 64'(lsu_req_ready), 64'h0);
        chk("mem_valid_t", 64'(mem_req_valid), 64'h0);
        adv();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        sample();
        chk("mem_valid_t1", 64'(mem_req_valid), 64'h1);
        chk("mem_wen_t1", 64'(mem_wen), 64'h0);
        chk("mem_addr_t1", 64'(mem_addr), 64'h8000_0000);
        adv();
        mem_req_ready = 1'b0;
        sample();
        chk("mem_valid_drop", 64'(mem_req_valid), 64'h0);
        adv();
        mem_rsp_valid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0013;
        sample();
        chk("ifu_rsp_valid", 64'(ifu_rsp_valid), 64'h1);
        chk("ifu_rdata", ifu_rdata, 64'hDEAD_BEEF_0000_0013);
        chk("lsu_rsp_quiet", 64'(lsu_rsp_valid), 64'h0);
        adv();
        mem_rsp_valid = 1'b0; mem_rdata = 64'h0;
        tick();

        // simultaneous requests: LSU first, IFU right after the LSU response
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
        sample();
        chk("both_lsu_ready", 64'(lsu_req_ready), 64'h1);
        chk("both_ifu_wait", 64'(ifu_req_ready), 64'h0);
        adv();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        sample();
        chk("both_mem_addr", 64'(mem_addr), 64'h8000_2000);
        adv();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h0102_0304_0506_0708;
        sample();
        chk("both_lsu_rsp", 64'(lsu_rsp_valid), 64'h1);
        chk("both_lsu_rdata", lsu_rdata, 64'h0102_0304_0506_0708);
        chk("both_ifu_rdata_zero", ifu_rdata, 64'h0);
        chk("both_no_ready_wait", 64'(ifu_req_ready), 64'h0);
        adv();
        mem_rsp_valid = 1'b0; mem_rdata = 64'h0;
        sample();
        chk("both_ifu_ready_next", 64'(ifu_req_ready), 64'h1);
        adv();
        ifu_req_valid = 1'b0;
        serve(0, 64'h0000_0000_0000_0093);

        // starvation: both held valid, expect L L L L I L L L L I
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000;
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("starve_lsu_grant", 64'(lsu_req_ready), 64'((i % 5) != 4));
            chk("starve_ifu_grant", 64'(ifu_req_ready), 64'((i % 5) == 4));
            adv();
            serve(0, 64'(i));
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        tick();

        // store with a slow downstream accept
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 64'h1122_3344_5566_7788; lsu_wmask = 8'h0F;
        sample();
        chk("st_lsu_ready", 64'(lsu_req_ready), 64'h1);
        adv();
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_wdata = 64'hFFFF_FFFF_FFFF_FFFF; lsu_wmask = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("st_valid_hold", 64'(mem_req_valid), 64'h1);
            chk("st_wen_hold", 64'(mem_wen), 64'h1);
            chk("st_wdata_hold", mem_wdata, 64'h1122_3344_5566_7788);
            chk("st_wmask_hold", 64'(mem_wmask), 64'h0F);
            adv();
        end
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        sample();
        chk("st_ack", 64'(lsu_rsp_valid), 64'h1);
        chk("st_no_ifu_rsp", 64'(ifu_rsp_valid), 64'h0);
        adv();
        mem_rsp_valid = 1'b0;
        tick();

        // reset while waiting for a response, then a stray response
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_4000;
        tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'hAAAA_5555_AAAA_5555;
        sample();
        chk("rw_ifu_rsp", 64'(ifu_rsp_valid), 64'h0);
        chk("rw_ifu_rdata", ifu_rdata, 64'h0);
        chk("rw_mem_valid", 64'(mem_req_valid), 64'h0);
        chk("rw_mem_addr", 64'(mem_addr), 64'h0);
        adv();
        mem_rsp_valid = 1'b0; mem_rdata = 64'h0;
        tick();

        // spurious responses in IDLE and in REQ
        mem_rsp_valid = 1'b1; mem_rdata = 64'h1234;
        sample();
        chk("sp_idle_ifu_rsp", 64'(ifu_rsp_valid), 64'h0);
        chk("sp_idle_lsu_rsp", 64'(lsu_rsp_valid), 64'h0);
        adv();
        mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_5000;
        sample();
        chk("sp_ifu_grant", 64'(ifu_req_ready), 64'h1);
        adv();
        ifu_req_valid = 1'b0; mem_rsp_valid = 1'b1;
        sample();
        chk("sp_req_ifu_rsp", 64'(ifu_rsp_valid), 64'h0);
        adv();
        mem_rsp_valid = 1'b0;
        sample();
        chk("sp_req_still_valid", 64'(mem_req_valid), 64'h1);
        adv();
        serve(0, 64'h5555);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
